// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, array geometry
// and the data-slot to array-word mapping.
package mem_pkg;
  localparam int MEM_DEPTH  = 64;
  localparam int ADDR_W     = 6;
  localparam int DATA_SLOTS = 16;
  localparam int SLOT_W     = 4;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  // Data slot i lives at word base+i, wrapping around the 64-word array.
  function automatic logic [ADDR_W-1:0] slot_word(input int base, input logic [SLOT_W-1:0] slot);
    return ADDR_W'((base + int'(slot)) % MEM_DEPTH);
  endfunction
endpackage

// File: rtl/mem_array.sv
// 64 x 32 storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [MEM_DEPTH];

  // Synchronous write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// Latency-modelled memory responder: one outstanding fetch or data request,
// data requests win over fetches, faults answer one cycle after acceptance.
module mem_responder
  import mem_pkg::*;
#(
  parameter int                    LAT       = 2,
  parameter int                    DATA_BASE = 48,
  parameter logic [DATA_SLOTS-1:0] RO_MASK   = 16'h0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch,
  input  logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              wait_instr,
  output logic              instr_segv,
  input  logic              ld,
  input  logic              st,
  input  logic [SLOT_W-1:0] mem_loca_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              wait_data,
  output logic              data_segv,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data
);
  // With LAT=1 a good request answers in the cycle after acceptance, so
  // there is no BUSY cycle at all.
  localparam logic       FAST     = (LAT == 1);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              op_ld, op_st, fault;
  logic [ADDR_W-1:0] word;
  logic [31:0]       wdata_q;

  logic              req_d, d_fault, i_fault, idle;
  logic              store_direct, store_busy;
  logic [ADDR_W-1:0] data_word, waddr;
  logic [31:0]       wr_data, rd;
  logic              we;

  assign req_d     = ld | st;
  assign data_word = slot_word(DATA_BASE, mem_loca_addr);
  assign d_fault   = (ld & st) | (st & RO_MASK[mem_loca_addr]);
  assign i_fault   = (pc[1:0] != 2'b00) | (pc[31:8] != 24'h0);
  assign idle      = (state == IDLE);

  // A store commits on the edge that enters RESP_D. Faulting stores never
  // get here, and reset gates the enable so an abandoned store is dropped.
  assign store_direct = FAST & idle & st & ~d_fault;
  assign store_busy   = (state == BUSY_D) & (cnt == 4'd1) & op_st;
  assign we      = resetn & (store_direct | store_busy | (idle & prog_we));
  assign waddr   = store_direct ? data_word : store_busy ? word : prog_addr;
  assign wr_data = store_direct ? wdata     : store_busy ? wdata_q : prog_data;

  mem_array u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_data),
    .raddr (word),
    .rdata (rd)
  );

  // Request FSM: accept in IDLE, count down in BUSY, one-cycle RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      op_ld   <= 1'b0;
      op_st   <= 1'b0;
      fault   <= 1'b0;
      word    <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_d) begin
            op_ld   <= ld;
            op_st   <= st;
            fault   <= d_fault;
            word    <= data_word;
            wdata_q <= wdata;
            cnt     <= (d_fault || FAST) ? 4'd0 : CNT_INIT;
            state   <= (d_fault || FAST) ? RESP_D : BUSY_D;
          end else if (fetch) begin
            op_ld <= 1'b0;
            op_st <= 1'b0;
            fault <= i_fault;
            word  <= pc[7:2];
            cnt   <= (i_fault || FAST) ? 4'd0 : CNT_INIT;
            state <= (i_fault || FAST) ? RESP_I : BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= (state == BUSY_I) ? RESP_I : RESP_D;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are only visible in the RESP states; everything else reads 0.
  assign wait_instr  = resetn & fetch & (state != RESP_I);
  assign wait_data   = resetn & req_d & (state != RESP_D);
  assign instruction = (state == RESP_I && !fault) ? rd : 32'h0;
  assign instr_segv  = (state == RESP_I) & fault;
  assign rdata       = (state == RESP_D && op_ld && !fault) ? rd : 32'h0;
  assign data_segv   = (state == RESP_D) & fault;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LAT=2, DATA_BASE=48, RO_MASK=16'h0004).
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch, ld, st, prog_we;
  logic [31:0] pc, wdata, prog_data;
  logic [3:0]  mem_loca_addr;
  logic [5:0]  prog_addr;
  logic [31:0] instruction, rdata;
  logic        wait_instr, instr_segv, wait_data, data_segv;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.LAT(2), .DATA_BASE(48), .RO_MASK(16'h0004)) dut (
    .clk(clk), .resetn(resetn),
    .fetch(fetch), .pc(pc), .instruction(instruction), .wait_instr(wait_instr), .instr_segv(instr_segv),
    .ld(ld), .st(st), .mem_loca_addr(mem_loca_addr), .wdata(wdata),
    .rdata(rdata), .wait_data(wait_data), .data_segv(data_segv),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  typedef struct {
    string       name;
    bit          is_fetch;
    logic [31:0] pc;
    logic        ld, st;
    logic [3:0]  slot;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_segv;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];

  function automatic vec_t mk(input string nm, input bit f, input logic [31:0] p, input logic l, input logic s,
                              input logic [3:0] sl, input logic [31:0] wd, input logic [31:0] ed,
                              input logic es, input int el);
    vec_t v;
    v.name = nm; v.is_fetch = f; v.pc = p; v.ld = l; v.st = s; v.slot = sl; v.wdata = wd;
    v.exp_data = ed; v.exp_segv = es; v.exp_lat = el;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drop_all();
    fetch = 0; ld = 0; st = 0; prog_we = 0;
  endtask

  // Called just after a rising edge; returns the cycle index of the response (-1 on timeout).
  task automatic wait_resp(input bit is_fetch, input int k0, output int k, output logic [31:0] d, output logic s);
    k = -1; d = '0; s = 1'b0;
    for (int i = k0; i < k0 + 30; i++) begin
      @(negedge clk);
      if (is_fetch ? !wait_instr : !wait_data) begin
        k = i;
        d = is_fetch ? instruction : rdata;
        s = is_fetch ? instr_segv : data_segv;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic prog(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  task automatic do_req(input vec_t v);
    int k; logic [31:0] d; logic s; vec_t e;
    sb.push_back(v);
    fetch = v.is_fetch; pc = v.pc; ld = v.ld; st = v.st; mem_loca_addr = v.slot; wdata = v.wdata;
    wait_resp(v.is_fetch, 0, k, d, s);
    e = sb.pop_front();
    check({e.name, "_data"}, d, e.exp_data);
    check({e.name, "_segv"}, 32'(s), 32'(e.exp_segv));
    check({e.name, "_lat"}, 32'(k), 32'(e.exp_lat));
    @(posedge clk); #1;
    drop_all();
  endtask

  initial begin
    int dk, ik, k;
    logic [31:0] dd, id, d;
    logic s;

    // Reset with requests asserted: everything must read 0.
    resetn = 0; fetch = 1; ld = 1; st = 0; pc = 32'h14; mem_loca_addr = 0; wdata = 0;
    prog_we = 0; prog_addr = 0; prog_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait_instr", 32'(wait_instr), 32'h0);
    check("rst_wait_data", 32'(wait_data), 32'h0);
    check("rst_outputs", instruction | rdata, 32'h0);
    check("rst_segv", 32'({instr_segv, data_segv}), 32'h0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    drop_all();
    @(posedge clk); #1;
    resetn = 1;

    prog(6'd5,  32'hDEADBEEF);
    prog(6'd0,  32'h11111111);
    prog(6'd63, 32'hCAFEF00D);
    prog(6'd48, 32'hA5A5A5A5);
    prog(6'd50, 32'h50505050);
    prog(6'd51, 32'h00000000);

    //                 name          fetch pc          ld st slot wdata         exp_data      segv lat
    vecs[0]  = mk("fetch_ok",      1, 32'h14,        0, 0, 0,  0,            32'hDEADBEEF, 0, 2);
    vecs[1]  = mk("fetch_misal",   1, 32'h16,        0, 0, 0,  0,            32'h0,        1, 1);
    vecs[2]  = mk("fetch_hi",      1, 32'h100,       0, 0, 0,  0,            32'h0,        1, 1);
    vecs[3]  = mk("fetch_w0",      1, 32'h0,         0, 0, 0,  0,            32'h11111111, 0, 2);
    vecs[4]  = mk("fetch_w63",     1, 32'hFC,        0, 0, 0,  0,            32'hCAFEF00D, 0, 2);
    vecs[5]  = mk("st_ro",         0, 0,             0, 1, 2,  32'h123,      32'h0,        1, 1);
    vecs[6]  = mk("ld_ro",         0, 0,             1, 0, 2,  0,            32'h50505050, 0, 2);
    vecs[7]  = mk("st_s3",         0, 0,             0, 1, 3,  32'h7,        32'h0,        0, 2);
    vecs[8]  = mk("ld_s3",         0, 0,             1, 0, 3,  0,            32'h7,        0, 2);
    vecs[9]  = mk("ldst",          0, 0,             1, 1, 0,  32'hBAD,      32'h0,        1, 1);
    vecs[10] = mk("ld_s0",         0, 0,             1, 0, 0,  0,            32'hA5A5A5A5, 0, 2);
    vecs[11] = mk("ld_s15",        0, 0,             1, 0, 15, 0,            32'hCAFEF00D, 0, 2);
    vecs[12] = mk("st_s15",        0, 0,             0, 1, 15, 32'h12345678, 32'h0,        0, 2);
    foreach (vecs[i]) do_req(vecs[i]);
    do_req(mk("fetch_alias", 1, 32'hFC, 0, 0, 0, 0, 32'h12345678, 0, 2));

    // fetch and ld together: load first, fetch accepted in the next IDLE cycle.
    fetch = 1; pc = 32'h14; ld = 1; mem_loca_addr = 3;
    dk = -1; ik = -1; dd = 0; id = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!wait_data && dk < 0) begin dk = i; dd = rdata; end
      if (!wait_instr) begin ik = i; id = instruction; break; end
      @(posedge clk); #1;
      if (dk >= 0) ld = 0;
    end
    check("both_data_lat", 32'(dk), 32'd2);
    check("both_data", dd, 32'h7);
    check("both_instr_lat", 32'(ik), 32'd5);
    check("both_instr", id, 32'hDEADBEEF);
    @(posedge clk); #1;
    drop_all();

    // prog_we while busy is ignored.
    fetch = 1; pc = 32'h0;
    @(posedge clk); #1;
    prog_we = 1; prog_addr = 6'd0; prog_data = 32'h99999999;
    wait_resp(1, 1, k, d, s);
    check("busyprog_lat", 32'(k), 32'd2);
    check("busyprog_data", d, 32'h11111111);
    @(posedge clk); #1;
    drop_all();
    do_req(mk("busyprog_after", 1, 32'h0, 0, 0, 0, 0, 32'h11111111, 0, 2));

    // prog_we alongside a fetch in IDLE: the fetch sees the new word.
    fetch = 1; pc = 32'h18; prog_we = 1; prog_addr = 6'd6; prog_data = 32'h66666666;
    @(negedge clk);
    check("idleprog_wait", 32'(wait_instr), 32'h1);
    @(posedge clk); #1;
    prog_we = 0;
    wait_resp(1, 1, k, d, s);
    check("idleprog_lat", 32'(k), 32'd2);
    check("idleprog_data", d, 32'h66666666);
    @(posedge clk); #1;
    drop_all();

    // Reset during BUSY_D of a store: abandoned, word 48 unchanged.
    st = 1; mem_loca_addr = 0; wdata = 32'hFFFF0000;
    @(posedge clk); #3;
    resetn = 0;
    #1;
    check("midrst_wait", 32'({wait_data, wait_instr}), 32'h0);
    check("midrst_out", rdata | 32'(data_segv), 32'h0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_cnt", 32'(dut.cnt), 32'h0);
    st = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1;
    do_req(mk("midrst_word", 0, 0, 1, 0, 0, 0, 32'hA5A5A5A5, 0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LAT, default 2: cycles from request acceptance to response, legal range 1..15.
REQ-002 SHALL have parameter DATA_BASE, default 48: array word index of data slot 0.
REQ-003 SHALL have parameter RO_MASK, default 16'h0000: bit i set means data slot i is read-only.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports fetch (in, 1) and pc (in, 32): instruction fetch request level and byte address.
REQ-007 SHALL have ports instruction (out, 32), wait_instr (out, 1) and instr_segv (out, 1): fetch response.
REQ-008 SHALL have ports ld (in, 1), st (in, 1), mem_loca_addr (in, 4) and wdata (in, 32): data request and data slot.
REQ-009 SHALL have ports rdata (out, 32), wait_data (out, 1) and data_segv (out, 1): data response.
REQ-010 SHALL have ports prog_we (in, 1), prog_addr (in, 6) and prog_data (in, 32): preload write port.

Function
REQ-011 SHALL hold a 64 x 32 storage array; data slot i maps to word DATA_BASE+i, modulo 64.
REQ-012 SHALL implement the FSM states IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D.
REQ-013 In IDLE, if ld|st is high, SHALL accept the data request, latch the address, wdata and op, and go to BUSY_D; otherwise, if fetch is high, SHALL accept the fetch and go to BUSY_I (data has priority).
REQ-014 On acceptance SHALL load a latency counter with LAT-1; a BUSY state SHALL move to its RESP state in the cycle its counter is 0, and SHALL otherwise decrement the counter.
REQ-015 A faulting request SHALL bypass the counter, go directly to its RESP state, and not access the array.
REQ-016 A fetch SHALL fault if pc[1:0]!=0 or pc[31:8]!=0; otherwise it SHALL read word pc[7:2].
REQ-017 A data request SHALL fault if ld and st are both high, or if st targets a slot whose RO_MASK bit is set.
REQ-018 A store SHALL write the array when entering RESP_D; a load SHALL drive rdata with the slot word in RESP_D.
REQ-019 wait_instr SHALL equal fetch & ~(state==RESP_I), and wait_data SHALL equal (ld|st) & ~(state==RESP_D); both SHALL be 0 while resetn is low.
REQ-020 With acceptance in cycle t, the response cycle SHALL be t+LAT for a non-faulting request and t+1 for a faulting one.
REQ-021 instruction/rdata and instr_segv/data_segv SHALL be valid only in RESP_I/RESP_D, and SHALL be 0 in every other state.
REQ-022 A RESP state SHALL last exactly one cycle and then return to IDLE; a request still high in IDLE SHALL be accepted as a new request.
REQ-023 The latched request SHALL be authoritative: a request dropped or changed while BUSY SHALL NOT alter the response.
REQ-024 prog_we SHALL write prog_data to prog_addr only while in IDLE; in any other state it SHALL be ignored.
REQ-025 When prog_we and a request are both present in IDLE, the preload write SHALL complete in the same cycle the request is accepted, so the request observes the preloaded value.

Reset
REQ-026 While resetn is low, the FSM SHALL be IDLE, the counter 0, and all outputs 0.
REQ-027 A reset in mid-operation SHALL abandon the request, and the abandoned store SHALL NOT write the array.
REQ-028 Array contents SHALL NOT be reset.

Structure
REQ-029 The state encodings, the array depth (64) and the data slot count (16) SHALL be defined in the shared package mem_pkg.
REQ-030 The storage array SHALL be a sub-module mem_array with one synchronous write port and one asynchronous read port.

Verification
REQ-031 LAT=2: preload word 5 = 32'hDEADBEEF, hold fetch with pc=32'h14 -> wait_instr high for 2 cycles, then instruction=32'hDEADBEEF with wait_instr low for one cycle.
REQ-032 With pc=32'h16 -> instr_segv=1 one cycle after acceptance and instruction=0.
REQ-033 RO_MASK=16'h0004: st to slot 2 -> data_segv=1 and word 50 unchanged; st to slot 3 with wdata=7, then ld slot 3 -> rdata=7.
REQ-034 fetch and ld rise in the same cycle -> the load completes first, then the fetch is accepted in the next IDLE cycle.
REQ-035 Reset pulse during BUSY_D of a store -> outputs 0, state IDLE, target word unchanged.
REQ-036 ld=st=1 -> data_segv=1, rdata=0, array unchanged.
